// File: rtl/inst_rom_arbiter.sv
// Two-requester arbiter in front of a single-cycle instruction ROM, pipelined at 1 access/cycle.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module inst_rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              flush,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when m0 was granted last, so m1 wins the next tie.
  logic rr_q, rr_d;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!flush) begin
      if (m0_req && m1_req) begin
        m0_gnt = !rr_q;
        m1_gnt = rr_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (m0_gnt)      rr_d = 1'b1;
    else if (m1_gnt) rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!flush) begin
      m0_gnt = m0_req;
      m1_gnt = m1_req && !m0_req;
    end
  end
`endif

  // Grant stage: load the ROM address register and record the owner.
  always_comb begin
    state_d    = IDLE;
    rom_ce_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    if (m0_gnt) begin
      state_d    = ACC0;
      rom_ce_d   = 1'b1;
      rom_addr_d = m0_addr;
    end else if (m1_gnt) begin
      state_d    = ACC1;
      rom_ce_d   = 1'b1;
      rom_addr_d = m1_addr;
    end
  end

  // Return stage: only the owner captures rom_inst, and flush kills it.
  always_comb begin
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    if (!flush) begin
      if (state_q == ACC0) begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = rom_inst;
      end else if (state_q == ACC1) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = rom_inst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_ce_q    <= 1'b0;
      rom_addr_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      rom_ce_q    <= rom_ce_d;
      rom_addr_q  <= rom_addr_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign rom_ce    = rom_ce_q;
  assign rom_addr  = rom_addr_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/inst_rom_arbiter.md
INST_ROM_ARBITER -- requirements
Module: inst_rom_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, requester/ROM address width in bits.
REQ-002 Parameter: DATA_W, default 32, instruction width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m0_req  input  1  requester 0 (instruction fetch) access request.
REQ-006 m0_addr  input  ADDR_W  requester 0 byte address; held stable while m0_req=1 and m0_gnt=0.
REQ-007 m0_gnt  output  1  requester 0 request accepted this cycle (combinational).
REQ-008 m0_rvalid  output  1  requester 0 read data valid (registered, one-cycle pulse).
REQ-009 m0_rdata  output  DATA_W  requester 0 read data (registered).
REQ-010 m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata  same as REQ-005..009 for requester 1 (debug/loader).
REQ-011 flush  input  1  discard all accesses not yet returned.
REQ-012 rom_ce  output  1  ROM chip enable, 1 = enabled (registered).
REQ-013 rom_addr  output  ADDR_W  ROM byte address (registered).
REQ-014 rom_inst  input  DATA_W  ROM combinational read data for current rom_addr.

Function
REQ-015 State machine on ROM stage owner: IDLE (no access in ROM stage), ACC0 (requester 0 owns), ACC1 (requester 1 owns).
REQ-016 Transition each edge: grant to m0 -> ACC0; grant to m1 -> ACC1; no grant or flush=1 -> IDLE.
REQ-017 At most one of m0_gnt/m1_gnt is 1 per cycle; gnt=0 for a requester whose req=0; gnt=0 for both while flush=1.
REQ-018 A grant is possible every cycle regardless of state (full pipelining, throughput 1 access/cycle).
REQ-019 On a grant in cycle N: rom_ce<=1 and rom_addr<=granted address at end of N; with no grant rom_ce<=0 and rom_addr holds.
REQ-020 In cycle N+1 with state ACC0/ACC1 and flush=0: owner's rdata<=rom_inst and owner's rvalid<=1 at end of N+1; response visible cycle N+2 (latency 2 from grant).
REQ-021 rvalid is 0 in every cycle not covered by REQ-020; rdata holds last captured value when rvalid=0.
REQ-022 The non-owner's rdata/rvalid are never modified by the owner's return.
REQ-023 flush=1 in cycle N+1 suppresses the return of the access granted in N (no rvalid, rdata unchanged); flush=1 in cycle N blocks the grant itself.
REQ-024 Address passes unmodified; word indexing of the ROM is the ROM's concern.

Reset
REQ-025 rst=1 immediately forces state=IDLE, rom_ce=0, rom_addr=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, round-robin pointer=favour m0.
REQ-026 rst asserted with an access in flight drops it; no rvalid is produced after rst deasserts for any pre-reset grant.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not granted last; pointer updates only on a grant; single request always granted.
REQ-028 ARB_ROUND_ROBIN_EN undefined: fixed priority, m0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-029 Reset then m0_req=1, m0_addr=0x0000_0004, rom_inst=0x3401_0020 -> m0_gnt=1 same cycle, rom_ce=1/rom_addr=0x4 next cycle, m0_rvalid=1/m0_rdata=0x3401_0020 two cycles after grant.
REQ-030 m0_req held 1 with addresses 0x0,0x4,0x8 on consecutive grants -> three consecutive m0_rvalid pulses, data in order, no bubbles.
REQ-031 m0_req=m1_req=1 for 4 cycles -> with ARB_ROUND_ROBIN_EN grants m0,m1,m0,m1; without it grants m0,m0,m0,m0 and m1_gnt=0.
REQ-032 Grant m1 at cycle N, flush=1 at N+1 -> m1_rvalid stays 0, m1_rdata unchanged, state IDLE at N+2.
REQ-033 rst pulsed in cycle after grant of m0 -> rom_ce=0, m0_rvalid=0 immediately and no later rvalid for that access.
REQ-034 No requests for 3 cycles -> rom_ce=0, rom_addr unchanged, both rvalid=0, state IDLE.
